button_debounce_repeat: RTL

BUTTON_DEBOUNCE_REPEAT -- requirements
Module: button_debounce_repeat

---
 rtl/button_debounce_repeat.sv | 131 +++++++++++++
 1 files changed

// File: rtl/button_debounce_repeat.sv
// Debounced push-buttons with press/release pulses and per-channel auto-repeat.
// Ports: clk, reset (async, active-low), btn_raw, repeat_en -> btn_level,
//   btn_press, btn_release, btn_strobe (one-cycle pulses), any_pressed.
module button_debounce_repeat #(
    parameter int NUM_CH          = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_raw,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_strobe,
    output logic              any_pressed
);

    localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] DLY_LAST  = 26'(REPEAT_DELAY - 1);
    localparam logic [25:0] RATE_LAST = 26'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic        meta;
        logic        sync;
        logic        level;
        logic        press;
        logic        rel;
        logic        strobe;
        logic [19:0] deb_cnt;
        logic [25:0] rpt_cnt;
        rpt_state_t  state;
        logic        deb_due;
        logic        rise;
        logic        fall;
        logic        rpt_due;

        // The new level is accepted on the edge where it has already
        // disagreed with btn_level for DEBOUNCE_CYCLES consecutive edges.
        assign deb_due = (sync != level) && (deb_cnt == DEB_LAST);
        assign rise    = deb_due && sync;
        assign fall    = deb_due && !sync;
        assign rpt_due = (state == ST_DELAY) ? (rpt_cnt == DLY_LAST)
                                             : (rpt_cnt == RATE_LAST);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                meta <= 1'b0;
                sync <= 1'b0;
            end else begin
                meta <= btn_raw[ch];
                sync <= meta;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                deb_cnt <= '0;
                level   <= 1'b0;
                press   <= 1'b0;
                rel     <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                if (sync == level) begin
                    deb_cnt <= '0;
                end else if (deb_due) begin
                    deb_cnt <= '0;
                    level   <= sync;
                    press   <= sync;
                    rel     <= !sync;
                end else if (deb_cnt < DEB_LAST) begin
                    deb_cnt <= deb_cnt + 20'd1;
                end
            end
        end

        // A release on the same edge as a due repeat takes priority,
        // so no strobe is issued for a button that is being let go.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= ST_IDLE;
                rpt_cnt <= '0;
                strobe  <= 1'b0;
            end else begin
                strobe <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        rpt_cnt <= '0;
                        if (rise) begin
                            state  <= ST_DELAY;
                            strobe <= 1'b1;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (fall || !level || !repeat_en[ch]) begin
                            state   <= ST_IDLE;
                            rpt_cnt <= '0;
                        end else if (rpt_due) begin
                            state   <= ST_REPEAT;
                            rpt_cnt <= '0;
                            strobe  <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 26'd1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        rpt_cnt <= '0;
                    end
                endcase
            end
        end

        assign btn_level[ch]   = level;
        assign btn_press[ch]   = press;
        assign btn_release[ch] = rel;
        assign btn_strobe[ch]  = strobe;
    end

    assign any_pressed = |btn_level;

endmodule
